seq_scan_ctrl: RTL and testbench

Sequencing controller for the serial pattern-detection path. On a start pulse it latches a parallel data word and a programmable bit pattern. It then streams the word MSB-first, one bit per clock, through an internal match window and counts overlapping pattern occurrences. Completion is reported with a one-cycle done strobe. It sits between the parallel register side of the design and the serial sequence-detector datapath, and replaces a hard-wired single-pattern detector with a configurable, job-based one.

---
 rtl/seq_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_seq_scan_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_scan_ctrl.sv
// Job-based serial pattern scanner: latches a word and a pattern on start, streams the word
// MSB-first through a match window and counts overlapping occurrences of the pattern.
module seq_scan_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic [PAT_W-1:0]  pattern_i,
  output logic              busy_o,
  output logic              bit_out_o,
  output logic              hit_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              done_o
);

  localparam int FILL_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam int IDX_W  = $clog2(DATA_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] word_q, word_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [PAT_W-1:0]  win_q, win_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hit_q, hit_d;
  logic              bit_q, bit_d;

  logic              shiftBit;
  logic [PAT_W-1:0]  winNext;
  logic              matchNow;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = SHIFT;
      SHIFT:   if (idx_q == IDX_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == SHIFT);
    done_o = (state_q == DONE);
  end

  // The window only qualifies once it holds PAT_W real bits of the current job.
  assign shiftBit = word_q[DATA_W-1];
  assign winNext  = {win_q[PAT_W-2:0], shiftBit};
  assign matchNow = (fill_q >= FILL_MAX) && (winNext == pat_q);

  always_comb begin
    word_d = word_q;
    pat_d  = pat_q;
    win_d  = win_q;
    fill_d = fill_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    hit_d  = hit_q;
    bit_d  = bit_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          word_d = din_i;
          pat_d  = pattern_i;
          win_d  = '0;
          fill_d = '0;
          idx_d  = '0;
          cnt_d  = '0;
        end
      end
      SHIFT: begin
        word_d = {word_q[DATA_W-2:0], 1'b0};
        win_d  = winNext;
        bit_d  = shiftBit;
        hit_d  = matchNow;
        if (matchNow && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
        if (fill_q != FILL_MAX) fill_d = fill_q + FILL_W'(1);
        idx_d  = idx_q + IDX_W'(1);
      end
      DONE: begin
        hit_d = 1'b0;
        bit_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q <= '0;
      pat_q  <= '0;
      win_q  <= '0;
      fill_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      hit_q  <= 1'b0;
      bit_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      pat_q  <= pat_d;
      win_q  <= win_d;
      fill_q <= fill_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      hit_q  <= hit_d;
      bit_q  <= bit_d;
    end
  end

  assign bit_out_o = bit_q;
  assign hit_o     = hit_q;
  assign count_o   = cnt_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Testbench for seq_scan_ctrl: table-driven jobs, reset/abort sequences and random jobs checked
// against a per-bit reference model; a second instance with a 2-bit counter covers saturation.
module tb_seq_scan_ctrl;
  localparam int DATA_W = 8;
  localparam int PAT_W  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] din;
  logic [3:0] pattern;
  logic       busy, bitOut, hit, done;
  logic [3:0] count;
  logic       busyS, bitOutS, hitS, doneS;
  logic [1:0] countS;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] din;
    logic [3:0] pat;
    int         expCount;
    int         expCountS;
    bit         perturb;
  } vec_t;

  seq_scan_ctrl #(.DATA_W(8), .PAT_W(4), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .din_i(din), .pattern_i(pattern),
    .busy_o(busy), .bit_out_o(bitOut), .hit_o(hit), .count_o(count), .done_o(done)
  );

  seq_scan_ctrl #(.DATA_W(8), .PAT_W(4), .CNT_W(2)) dutSat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .din_i(din), .pattern_i(pattern),
    .busy_o(busyS), .bit_out_o(bitOutS), .hit_o(hitS), .count_o(countS), .done_o(doneS)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  // Reference: bit j of the stream is din[DATA_W-1-j]; a hit at j means the PAT_W bits
  // ending at j, read as a number, equal the pattern.
  function automatic bit patHit(input logic [7:0] d, input logic [3:0] p, input int j);
    int w;
    if (j < PAT_W - 1) return 1'b0;
    w = (int'(d) >> (DATA_W - 1 - j)) & ((1 << PAT_W) - 1);
    return w == int'(p);
  endfunction

  function automatic int hitsUpTo(input logic [7:0] d, input logic [3:0] p, input int k);
    int n = 0;
    for (int j = 0; j <= k; j++) if (patHit(d, p, j)) n++;
    return n;
  endfunction

  function automatic int sat(input int n, input int w);
    return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic [7:0] d, input logic [3:0] p);
    rst = r;
    start = s;
    din = d;
    pattern = p;
    step();
  endtask

  task automatic checkOutput(input string name, input logic eBusy, input logic eDone, input logic eHit,
                             input logic eBit, input logic [3:0] eCnt, input logic [1:0] eCntS);
    logic [9:0] act, exp;
    act = {busy, done, hit, bitOut, count, countS};
    exp = {eBusy, eDone, eHit, eBit, eCnt, eCntS};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: busy,done,hit,bit,cnt,cntS got %b expected %b", name, act, exp);
    end
  endtask

  task automatic runJob(input logic [7:0] d, input logic [3:0] p, input bit perturb, input bit holdStart,
                        input int expFinal, input int expFinalS, input string tag,
                        output int lastCnt, output int lastCntS);
    int n;
    applyStimulus(1'b0, 1'b1, d, p);
    checkOutput({tag, " accept"}, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0);
    for (int k = 0; k < DATA_W; k++) begin
      if (perturb) begin
        start = (k == 2);
        din = 8'($urandom);
        pattern = 4'($urandom);
        if (k == 2) begin
          din = ~d;
          pattern = ~p;
        end
      end else begin
        start = holdStart;
      end
      step();
      n = hitsUpTo(d, p, k);
      checkOutput($sformatf("%s shift%0d", tag, k), k < DATA_W - 1, k == DATA_W - 1,
                  patHit(d, p, k), d[DATA_W-1-k], 4'(sat(n, 4)), 2'(sat(n, 2)));
    end
    start = perturb ? 1'b1 : holdStart;
    if (perturb) begin
      din = 8'($urandom);
      pattern = 4'($urandom);
    end
    step();
    n = hitsUpTo(d, p, DATA_W - 1);
    checkOutput({tag, " idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 4'(sat(n, 4)), 2'(sat(n, 2)));
    if (expFinal >= 0) begin
      checks++;
      if (int'(count) != expFinal || int'(countS) != expFinalS) begin
        errors++;
        $display("[TB] FAIL %s final count: got %0d/%0d expected %0d/%0d", tag, count, countS,
                 expFinal, expFinalS);
      end
    end
    if (!holdStart) start = 1'b0;
    lastCnt = sat(n, 4);
    lastCntS = sat(n, 2);
  endtask

  initial begin
    vec_t vecs[6];
    int lc, lcS;
    bit hs;
    vecs[0] = '{8'h55, 4'b0101, 3, 3, 1'b0};
    vecs[1] = '{8'hFF, 4'b1111, 5, 3, 1'b0};
    vecs[2] = '{8'h55, 4'b0101, 3, 3, 1'b1};
    vecs[3] = '{8'h00, 4'b0000, 5, 3, 1'b0};
    vecs[4] = '{8'h0F, 4'b1111, 1, 1, 1'b0};
    vecs[5] = '{8'hA5, 4'b1010, 1, 1, 1'b1};

    // Reset held with start high must keep everything at zero.
    rst = 1'b1; start = 1'b1; din = 8'h55; pattern = 4'b0101;
    for (int i = 0; i < 2; i++) begin
      step();
      checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0);
    end

    for (int i = 0; i < 6; i++)
      runJob(vecs[i].din, vecs[i].pat, vecs[i].perturb, 1'b0, vecs[i].expCount, vecs[i].expCountS,
             $sformatf("vec%0d", i), lc, lcS);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 8'($urandom), 4'($urandom));
      checkOutput("idle hold", 1'b0, 1'b0, 1'b0, 1'b0, 4'(lc), 2'(lcS));
    end

    // Abort during the 4th shift cycle: no done afterwards, then a clean job.
    applyStimulus(1'b0, 1'b1, 8'h55, 4'b0101);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h55, 4'b0101);
    applyStimulus(1'b1, 1'b0, 8'h55, 4'b0101);
    checkOutput("abort", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h55, 4'b0101);
      checkOutput("post-abort", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0);
    end
    runJob(8'h55, 4'b0101, 1'b0, 1'b0, 3, 3, "after-abort", lc, lcS);

    // start held high: back-to-back jobs separated by exactly one idle cycle.
    runJob(8'h05, 4'b0101, 1'b0, 1'b1, 1, 1, "b2b1", lc, lcS);
    runJob(8'hA0, 4'b0101, 1'b0, 1'b0, 0, 0, "b2b2", lc, lcS);

    for (int r = 0; r < 40; r++) begin
      hs = ($urandom_range(0, 3) == 0);
      runJob(8'($urandom), 4'($urandom), 1'b0, hs, -1, -1, $sformatf("rnd%0d", r), lc, lcS);
      if (!hs) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          applyStimulus(1'b0, 1'b0, 8'($urandom), 4'($urandom));
          checkOutput("rnd gap", 1'b0, 1'b0, 1'b0, 1'b0, 4'(lc), 2'(lcS));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
